// File: rtl/parity_rx_if.sv
// Serial-receive handshake bundle for parity_rx.
// Master side drives the line and strobe; slave side reports frames.
interface parity_rx_if #(
   parameter int DW = 6
);
   logic          bit_en;
   logic          sin;
   logic [DW-1:0] data_out;
   logic          valid;
   logic          perr;
   logic          ferr;
   logic          busy;

   modport master (
      output bit_en, sin,
      input  data_out, valid, perr, ferr, busy
   );

   modport slave (
      input  bit_en, sin,
      output data_out, valid, perr, ferr, busy
   );
endinterface

// File: rtl/parity_rx.sv
// Strobed serial receiver: start, DW data bits LSB first, parity, stop.
// Frames with parity or stop errors are still delivered, just flagged.
module parity_rx #(
   parameter int DW  = 6,
   parameter int ODD = 0
) (
   input  logic        clk,
   input  logic        rst,
   parity_rx_if.slave  bus
);
   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] sh_q, sh_d;
   logic          par_q, par_d;
   logic [DW-1:0] data_q, data_d;
   logic          perr_q, perr_d;
   logic          ferr_q, ferr_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      par_d   = par_q;
      data_d  = data_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      valid_d = 1'b0;
      if (bus.bit_en) begin
         unique case (state_q)
            IDLE: begin
               if (!bus.sin) begin
                  state_d = DATA;
                  cnt_d   = '0;
               end
            end
            DATA: begin
               sh_d[cnt_q] = bus.sin;
               cnt_d       = cnt_q + CW'(1);
               if (cnt_q == CW'(DW - 1)) state_d = PARITY;
            end
            PARITY: begin
               par_d   = bus.sin;
               state_d = STOP;
            end
            STOP: begin
               // Everything about the frame publishes on this one edge
               data_d  = sh_q;
               perr_d  = par_q ^ (^sh_q) ^ (ODD != 0);
               ferr_d  = ~bus.sin;
               valid_d = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   assign bus.data_out = data_q;
   assign bus.valid    = valid_q;
   assign bus.perr     = perr_q;
   assign bus.ferr     = ferr_q;
   assign bus.busy     = busy_q;
endmodule
